riscv_int_controller_mc: RTL
============================

Name: riscv_int_controller_mc

Overview:
Multi-line successor of the single-request core interrupt controller. It accepts NUM_IRQ independent interrupt lines, each configured as level- or edge-triggered. Lines are masked per line and privilege-qualified, and the highest-priority line is selected (lowest index wins). The block then runs the same request/ack/kill handshake toward the core controller, presenting a registered ID and secure bit.

Parameters:
NUM_IRQ, 32, number of interrupt lines (2..64)
ID_W, 5, width of the interrupt ID; must satisfy 2**ID_W >= NUM_IRQ
EDGE_MASK, 0, NUM_IRQ-bit constant; bit k=1 makes line k edge-triggered (rising), 0 makes it level-triggered
PULP_SECURE, 0, 1 enables privilege-qualified enabling with per-line secure bits

Ports:
clk  in  1  core clock
rst_n  in  1  reset, asynchronous, active-low
irq_i  in  NUM_IRQ  interrupt lines
irq_en_i  in  NUM_IRQ  per-line enable mask (CSR mie-style)
irq_sec_i  in  NUM_IRQ  per-line secure attribute
m_IE_i  in  1  global M-mode interrupt enable
u_IE_i  in  1  global U-mode interrupt enable
current_priv_lvl_i  in  2  privilege level; M=2'b11, U=2'b00
ctrl_ack_i  in  1  core controller accepted the request
ctrl_kill_i  in  1  core controller withdrew the request (e.g. flush)
irq_req_ctrl_o  out  1  request to core controller
irq_id_ctrl_o  out  ID_W  ID of the requested line
irq_sec_ctrl_o  out  1  secure bit of the requested line
irq_pending_o  out  NUM_IRQ  current pending vector (status/CSR mip)

Behaviour:
- Reset (asynchronous assert, synchronous release): state=IDLE, edge-pending regs=0, previous-sample regs=0, id_q=0, sec_q=0. All outputs 0 except irq_pending_o, which reflects level lines combinationally.
- Pending vector, per line k:
  - Level line: pend[k] = irq_i[k].
  - Edge line: set when irq_i[k]=1 and its previous sample=0. Cleared on the cycle ctrl_ack_i=1 in IRQ_PENDING with id_q==k. If a new edge coincides with the clear, set wins.
- Eligibility:
  - cand = pend & irq_en_i.
  - PULP_SECURE=0: line eligible iff m_IE_i.
  - PULP_SECURE=1: line k eligible iff (priv==M & m_IE_i) | (priv==U & (u_IE_i | irq_sec_i[k])).
  - Any other priv value: nothing eligible.
- Selection: lowest index among eligible candidates. The ID is zero-extended to ID_W.
- FSM (IDLE, IRQ_PENDING, IRQ_DONE):
  - IDLE: if any eligible candidate, capture id_q and sec_q, go to IRQ_PENDING next cycle. Latency from line assertion to irq_req_ctrl_o is 1 cycle for a level line and 2 cycles for an edge line (edge register stage).
  - IRQ_PENDING: ctrl_ack_i -> IRQ_DONE (ack has priority over a simultaneous kill). ctrl_kill_i alone -> IDLE with pending bits untouched. Otherwise stay. id_q and sec_q stay frozen even if higher-priority lines arrive or the line drops.
  - IRQ_DONE: sec_q<=0, -> IDLE. id_q holds its value. A new request can be raised at the earliest 1 cycle after IRQ_DONE.
- Outputs: irq_req_ctrl_o = (state==IRQ_PENDING); irq_id_ctrl_o=id_q; irq_sec_ctrl_o=sec_q; irq_pending_o=pend.
- Level lines are not cleared by the block; software clears the source. Re-request after DONE occurs if the line is still high.
- ctrl_ack_i and ctrl_kill_i are ignored outside IRQ_PENDING.
- Reset mid-handshake: returns to IDLE immediately and drops the request; edge-pending state is lost.

Test Plan:
1. m_IE_i=1, priv=M, all level, en=all 1; assert irq_i[3] and irq_i[7] together -> after 1 cycle req=1, id=3; ack -> DONE then IDLE; line 3 still high -> new req with id=3.
2. EDGE_MASK bit 5=1; pulse irq_i[5] for 1 cycle, m_IE_i=1 -> irq_pending_o[5]=1 sticky; req id=5 2 cycles after the pulse; ack clears pending[5]. A second pulse in the ack cycle -> pending[5] stays 1.
3. Request id=2 pending; assert ctrl_kill_i -> IDLE, pending[2] unchanged, re-request id=2 next cycle. Assert ack and kill together -> IRQ_DONE.
4. PULP_SECURE=1, priv=U, u_IE_i=0: irq_i[4] with sec[4]=1 and irq_i[1] with sec[1]=0 -> id=4, irq_sec_ctrl_o=1, cleared to 0 in the cycle after ack. priv=2'b01 -> no request.
5. irq_en_i[0]=0 with irq_i[0]=1 -> no request, pending[0]=1. Set m_IE_i=0 with all lines high -> req stays 0.
6. Drop rst_n while in IRQ_PENDING -> req, id and sec go to 0 immediately, edge pending cleared; release -> normal operation resumes.

Source files
------------

// File: rtl/riscv_int_controller_mc.sv
// rtl/riscv_int_controller_mc.sv - multi-line level/edge interrupt controller with core req/ack/kill handshake
module riscv_int_controller_mc #(
    parameter int                 NUM_IRQ     = 32,
    parameter int                 ID_W        = 5,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK   = '0,
    parameter bit                 PULP_SECURE = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [NUM_IRQ-1:0] irq_en_i,
    input  logic [NUM_IRQ-1:0] irq_sec_i,
    input  logic               m_IE_i,
    input  logic               u_IE_i,
    input  logic [1:0]         current_priv_lvl_i,
    input  logic               ctrl_ack_i,
    input  logic               ctrl_kill_i,
    output logic               irq_req_ctrl_o,
    output logic [ID_W-1:0]    irq_id_ctrl_o,
    output logic               irq_sec_ctrl_o,
    output logic [NUM_IRQ-1:0] irq_pending_o
);

    localparam logic [1:0] IDLE        = 2'b00;
    localparam logic [1:0] IRQ_PENDING = 2'b01;
    localparam logic [1:0] IRQ_DONE    = 2'b10;

    localparam logic [1:0] PRIV_M = 2'b11;
    localparam logic [1:0] PRIV_U = 2'b00;

    logic [1:0]         state_q;
    logic [ID_W-1:0]    id_q;
    logic               sec_q;
    logic [NUM_IRQ-1:0] prev_q;
    logic [NUM_IRQ-1:0] edge_pend_q;

    logic [NUM_IRQ-1:0] edge_rise;
    logic [NUM_IRQ-1:0] edge_clr;
    logic [NUM_IRQ-1:0] pend;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] cand;
    logic               ack_hit;
    logic               sel_valid;
    logic [ID_W-1:0]    sel_id;
    logic               sel_sec;

    assign ack_hit   = (state_q == IRQ_PENDING) && ctrl_ack_i;
    assign edge_rise = irq_i & ~prev_q & EDGE_MASK;
    assign pend      = (irq_i & ~EDGE_MASK) | (edge_pend_q & EDGE_MASK);
    assign cand      = pend & irq_en_i & eligible;

    // Only the acknowledged line loses its edge-pending bit.
    always_comb begin
        edge_clr = '0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            edge_clr[k] = ack_hit && (id_q == ID_W'(k));
        end
    end

    always_comb begin
        eligible = '0;
        if (PULP_SECURE) begin
            if (current_priv_lvl_i == PRIV_M) begin
                eligible = {NUM_IRQ{m_IE_i}};
            end else if (current_priv_lvl_i == PRIV_U) begin
                eligible = {NUM_IRQ{u_IE_i}} | irq_sec_i;
            end
        end else begin
            eligible = {NUM_IRQ{m_IE_i}};
        end
    end

    // Scan from the top so the lowest eligible index is the last one written.
    always_comb begin
        sel_valid = 1'b0;
        sel_id    = '0;
        sel_sec   = 1'b0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (cand[k]) begin
                sel_valid = 1'b1;
                sel_id    = ID_W'(k);
                sel_sec   = irq_sec_i[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            id_q        <= '0;
            sec_q       <= 1'b0;
            prev_q      <= '0;
            edge_pend_q <= '0;
        end else begin
            prev_q      <= irq_i;
            edge_pend_q <= ((edge_pend_q & ~edge_clr) | edge_rise) & EDGE_MASK;
            case (state_q)
                IDLE: begin
                    if (sel_valid) begin
                        state_q <= IRQ_PENDING;
                        id_q    <= sel_id;
                        sec_q   <= sel_sec;
                    end
                end
                IRQ_PENDING: begin
                    if (ctrl_ack_i) begin
                        state_q <= IRQ_DONE;
                    end else if (ctrl_kill_i) begin
                        state_q <= IDLE;
                    end
                end
                IRQ_DONE: begin
                    sec_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign irq_req_ctrl_o = (state_q == IRQ_PENDING);
    assign irq_id_ctrl_o  = id_q;
    assign irq_sec_ctrl_o = sec_q;
    assign irq_pending_o  = pend;

endmodule
